// File: rtl/uart_packet_parser.sv
// uart_packet_parser: frames the UART byte stream (SYNC, CMD, LEN_H, LEN_L,
// payload, CHK) and streams payload bytes out through a first-word-fall-through
// FIFO. Each frame closes with a one-cycle pkt_done or pkt_err pulse.
//
// state     | meaning
// ----------+-----------------------------------------------
// S_IDLE    | hunting for SYNC_BYTE, other bytes dropped
// S_CMD     | next byte is the command
// S_LEN_H   | next byte is length high byte
// S_LEN_L   | next byte is length low byte, length checked
// S_PAYLOAD | payload bytes pushed into the FIFO
// S_CHK     | next byte is the XOR checksum
module uart_packet_parser #(
  parameter logic [7:0] SYNC_BYTE      = 8'hA5,
  parameter int         MAX_LEN        = 1024,
  parameter int         FIFO_DEPTH     = 16,
  parameter int         TIMEOUT_CYCLES = 50000
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic [7:0]  m_data,
  output logic        m_valid,
  input  logic        m_ready,
  output logic [7:0]  cmd,
  output logic [15:0] pkt_len,
  output logic        busy,
  output logic        pkt_done,
  output logic        pkt_err,
  output logic [2:0]  err_code
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int TW = $clog2(TIMEOUT_CYCLES);
  localparam logic [TW-1:0] TIMER_LOAD = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [16:0]   MAX_LEN_W  = 17'(MAX_LEN);

  typedef enum logic [2:0] {
    S_IDLE, S_CMD, S_LEN_H, S_LEN_L, S_PAYLOAD, S_CHK
  } state_t;

  state_t        state, state_nxt;
  logic [7:0]    acc;
  logic [15:0]   remaining;
  logic [TW-1:0] timer;
  logic          ovf;
  logic          done_set, err_set;
  logic [2:0]    err_nxt;
  logic          timeout;
  logic          push_en;
  logic [15:0]   len_full;

  logic [7:0]    mem [FIFO_DEPTH];
  logic [AW:0]   wr_ptr, rd_ptr;
  logic          full, empty, do_push, do_pop;

  assign len_full = {pkt_len[15:8], rx_data};
  // The timer is a down-counter reloaded by every strobe; reaching zero with no
  // strobe on the edge means TIMEOUT_CYCLES idle clocks have elapsed.
  assign timeout  = (state != S_IDLE) && !rx_valid && (timer == '0);

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= S_IDLE;
    else          state <= state_nxt;
  end

  // Next-state decode plus the end-of-frame verdict.
  always_comb begin
    state_nxt = state;
    done_set  = 1'b0;
    err_set   = 1'b0;
    err_nxt   = err_code;
    if (timeout) begin
      state_nxt = S_IDLE;
      err_set   = 1'b1;
      err_nxt   = 3'd3;
    end else if (rx_valid) begin
      case (state)
        S_IDLE:    if (rx_data == SYNC_BYTE) state_nxt = S_CMD;
        S_CMD:     state_nxt = S_LEN_H;
        S_LEN_H:   state_nxt = S_LEN_L;
        S_LEN_L: begin
          if ({1'b0, len_full} > MAX_LEN_W) begin
            state_nxt = S_IDLE;
            err_set   = 1'b1;
            err_nxt   = 3'd2;
          end else if (len_full == 16'd0) begin
            state_nxt = S_CHK;
          end else begin
            state_nxt = S_PAYLOAD;
          end
        end
        S_PAYLOAD: if (remaining == 16'd1) state_nxt = S_CHK;
        S_CHK: begin
          state_nxt = S_IDLE;
          if (ovf) begin
            err_set = 1'b1;
            err_nxt = 3'd4;
          end else if (rx_data != acc) begin
            err_set = 1'b1;
            err_nxt = 3'd1;
          end else begin
            done_set = 1'b1;
          end
        end
        default:   state_nxt = S_IDLE;
      endcase
    end
  end

  // State-derived outputs.
  always_comb begin
    busy    = (state != S_IDLE);
    push_en = rx_valid && (state == S_PAYLOAD);
  end

  // Frame fields, checksum, counters and result pulses.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cmd       <= 8'h00;
      pkt_len   <= 16'h0000;
      acc       <= 8'h00;
      remaining <= 16'h0000;
      timer     <= '0;
      ovf       <= 1'b0;
      pkt_done  <= 1'b0;
      pkt_err   <= 1'b0;
      err_code  <= 3'd0;
    end else begin
      pkt_done <= done_set;
      pkt_err  <= err_set;
      if (err_set) err_code <= err_nxt;
      if (rx_valid)
        timer <= TIMER_LOAD;
      else if (state != S_IDLE && timer != '0)
        timer <= timer - 1'b1;
      if (rx_valid) begin
        case (state)
          S_IDLE: if (rx_data == SYNC_BYTE) begin
            acc <= 8'h00;
            ovf <= 1'b0;
          end
          S_CMD: begin
            cmd <= rx_data;
            acc <= acc ^ rx_data;
          end
          S_LEN_H: begin
            pkt_len[15:8] <= rx_data;
            acc           <= acc ^ rx_data;
          end
          S_LEN_L: begin
            pkt_len[7:0] <= rx_data;
            acc          <= acc ^ rx_data;
            remaining    <= len_full;
          end
          S_PAYLOAD: begin
            acc       <= acc ^ rx_data;
            remaining <= remaining - 16'd1;
            if (full && !do_pop) ovf <= 1'b1;
          end
          S_CHK:   ovf <= 1'b0;
          default: ;
        endcase
      end
    end
  end

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign m_valid = !empty;
  assign m_data  = empty ? 8'h00 : mem[rd_ptr[AW-1:0]];
  assign do_pop  = m_valid && m_ready;
  // A pop on the same edge frees the slot the full FIFO would otherwise refuse.
  assign do_push = push_en && (!full || do_pop);

  // FIFO pointers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // FIFO storage; contents are don't-care until the write pointer covers them.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= rx_data;
  end

endmodule

// File: tb/tb_uart_packet_parser.sv
// Testbench for uart_packet_parser: directed frames, scoreboard queues for
// payload bytes and end-of-frame pulses, monitors compare on the falling edge.
module tb_uart_packet_parser;

  localparam int T = 300;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [7:0]  rx_data = 8'h00;
  logic        rx_valid = 1'b0;
  logic [7:0]  m_data;
  logic        m_valid;
  logic        m_ready = 1'b0;
  logic [7:0]  cmd;
  logic [15:0] pkt_len;
  logic        busy;
  logic        pkt_done;
  logic        pkt_err;
  logic [2:0]  err_code;

  uart_packet_parser #(
    .SYNC_BYTE(8'hA5), .MAX_LEN(1024), .FIFO_DEPTH(16), .TIMEOUT_CYCLES(T)
  ) dut (
    .clk(clk), .reset_n(reset_n), .rx_data(rx_data), .rx_valid(rx_valid),
    .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready),
    .cmd(cmd), .pkt_len(pkt_len), .busy(busy),
    .pkt_done(pkt_done), .pkt_err(pkt_err), .err_code(err_code)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    bit          is_err;
    logic [2:0]  code;
    logic [7:0]  cmd;
    logic [15:0] len;
    int          cyc;
  } evt_t;

  evt_t       evq[$];
  logic [7:0] dq[$];
  logic [7:0] pl[$];
  int         checks = 0;
  int         errors = 0;
  logic [2:0] last_code = 3'd0;
  evt_t       ev;
  logic [7:0] exp_b;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Payload monitor: every accepted beat must match the next queued byte.
  always @(negedge clk) begin
    if (reset_n && m_valid === 1'b1 && m_ready === 1'b1) begin
      if (dq.size() == 0) check("unexpected_beat", {24'h0, m_data}, 32'h1FF);
      else begin
        exp_b = dq.pop_front();
        check("m_data", {24'h0, m_data}, {24'h0, exp_b});
      end
    end
  end

  // Pulse monitor: kind, cycle, code and frame fields of every done/err pulse.
  always @(negedge clk) begin
    if (!reset_n) last_code = 3'd0;
    else if (pkt_done === 1'b1 || pkt_err === 1'b1) begin
      if (evq.size() == 0) check("unexpected_pulse", {30'h0, pkt_done, pkt_err}, 32'h0);
      else begin
        ev = evq.pop_front();
        check("pulse_kind", {30'h0, pkt_done, pkt_err}, ev.is_err ? 32'h1 : 32'h2);
        check("pulse_cycle", cyc, ev.cyc);
        if (ev.is_err) begin
          check("err_code", {29'h0, err_code}, {29'h0, ev.code});
          last_code = ev.code;
        end else begin
          check("done_cmd", {24'h0, cmd}, {24'h0, ev.cmd});
          check("done_len", {16'h0, pkt_len}, {16'h0, ev.len});
          check("err_code_held", {29'h0, err_code}, {29'h0, last_code});
        end
      end
    end
  end

  task automatic send(input logic [7:0] b);
    rx_data  = b;
    rx_valid = 1'b1;
    @(posedge clk); #1;
    rx_valid = 1'b0;
  endtask

  task automatic expect_evt(input bit is_err, input logic [2:0] code,
                            input logic [7:0] c, input logic [15:0] len, input int at);
    evt_t e;
    e.is_err = is_err; e.code = code; e.cmd = c; e.len = len; e.cyc = at;
    evq.push_back(e);
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Sends a full frame with payload pl; n_keep bytes are expected out of the FIFO.
  task automatic run_frame(input logic [7:0] c, input logic [7:0] chk,
                           input logic [2:0] code, input int n_keep);
    logic [15:0] len;
    len = 16'(pl.size());
    send(8'hA5);
    send(c);
    send(len[15:8]);
    send(len[7:0]);
    foreach (pl[i]) begin
      if (i < n_keep) dq.push_back(pl[i]);
      send(pl[i]);
    end
    expect_evt(code != 3'd0, code, c, len, cyc + 1);
    send(chk);
  endtask

  initial begin
    wait_cycles(3);
    check("rst_m_valid", {31'h0, m_valid}, 32'h0);
    check("rst_m_data", {24'h0, m_data}, 32'h0);
    check("rst_busy", {31'h0, busy}, 32'h0);
    check("rst_cmd", {24'h0, cmd}, 32'h0);
    check("rst_pkt_len", {16'h0, pkt_len}, 32'h0);
    check("rst_pkt_done", {31'h0, pkt_done}, 32'h0);
    check("rst_pkt_err", {31'h0, pkt_err}, 32'h0);
    check("rst_err_code", {29'h0, err_code}, 32'h0);
    reset_n = 1'b1;
    wait_cycles(2);
    m_ready = 1'b1;

    // good 3-byte frame: 01^00^03^10^20^30 = 02
    pl = '{8'h10, 8'h20, 8'h30};
    run_frame(8'h01, 8'h02, 3'd0, 3);
    wait_cycles(4);
    check("busy_after_done", {31'h0, busy}, 32'h0);

    // same frame, bad checksum: payload still emitted
    run_frame(8'h01, 8'h23, 3'd1, 3);
    wait_cycles(4);

    // garbage then zero-length frame: 02^00^00 = 02
    send(8'h00); send(8'hFF); send(8'h5A);
    check("busy_garbage", {31'h0, busy}, 32'h0);
    pl = {};
    run_frame(8'h02, 8'h02, 3'd0, 0);
    wait_cycles(4);

    // length 1025 rejected on the LEN_L byte
    send(8'hA5); send(8'h01); send(8'h04);
    expect_evt(1'b1, 3'd2, 8'h01, 16'h0401, cyc + 1);
    send(8'h01);
    wait_cycles(1);
    check("busy_after_len_err", {31'h0, busy}, 32'h0);
    pl = '{8'h10, 8'h20, 8'h30};
    run_frame(8'h01, 8'h02, 3'd0, 3);
    wait_cycles(4);

    // timeout after the LEN_L byte
    send(8'hA5); send(8'h01); send(8'h00);
    expect_evt(1'b1, 3'd3, 8'h01, 16'h0005, cyc + 1 + T);
    send(8'h05);
    wait_cycles(T - 3);
    check("busy_before_timeout", {31'h0, busy}, 32'h1);
    wait_cycles(10);
    check("busy_after_timeout", {31'h0, busy}, 32'h0);
    check("timeout_seen", evq.size(), 0);

    // overflow: 20 bytes 40..53, consumer stalled; 01^00^14^(xor payload=00) = 15
    m_ready = 1'b0;
    pl = {};
    for (int i = 0; i < 20; i++) pl.push_back(8'h40 + 8'(i));
    run_frame(8'h01, 8'h15, 3'd4, 16);
    wait_cycles(3);
    check("ovf_m_valid", {31'h0, m_valid}, 32'h1);
    m_ready = 1'b1;
    wait_cycles(25);
    check("ovf_drained", {31'h0, m_valid}, 32'h0);
    check("ovf_all_bytes", dq.size(), 0);

    // reset in the middle of a payload
    m_ready = 1'b0;
    send(8'hA5); send(8'h03); send(8'h00); send(8'h08);
    send(8'h11); send(8'h22); send(8'h33); send(8'h44);
    check("mid_busy", {31'h0, busy}, 32'h1);
    reset_n = 1'b0;
    #1;
    check("mr_m_valid", {31'h0, m_valid}, 32'h0);
    check("mr_m_data", {24'h0, m_data}, 32'h0);
    check("mr_busy", {31'h0, busy}, 32'h0);
    check("mr_cmd", {24'h0, cmd}, 32'h0);
    check("mr_pkt_len", {16'h0, pkt_len}, 32'h0);
    check("mr_err_code", {29'h0, err_code}, 32'h0);
    wait_cycles(2);
    reset_n = 1'b1;
    wait_cycles(2);
    check("post_rst_m_valid", {31'h0, m_valid}, 32'h0);
    m_ready = 1'b1;

    // recovery frame: 07^00^02^AA^55 = FA
    pl = '{8'hAA, 8'h55};
    run_frame(8'h07, 8'hFA, 3'd0, 2);
    wait_cycles(6);

    check("data_queue_empty", dq.size(), 0);
    check("event_queue_empty", evq.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
